flag_branch_unit: RTL

- Consumes the EX-stage ALU flag outputs (ZVN, FlagWriteEnable) and owns the architectural Z/V/N flag register.
- Resolves B/BR branches in the ID stage against those flags: taken decision, target address, one-cycle flag-hazard stall.
- Keeps saturating branch/taken performance counters.
- Sits between the EX-stage ALU and the IF/ID control path of the 16-bit pipelined CPU.

---
 rtl/flag_branch_unit_pkg.sv | 37 +++
 rtl/flag_branch_unit_if.sv | 44 ++++
 rtl/flag_branch_unit_branch_cond.sv | 30 +++
 rtl/flag_branch_unit.sv | 80 ++++++++
 4 files changed

// File: rtl/flag_branch_unit_pkg.sv
// Shared CPU constants for the flag/branch path: condition codes, opcodes,
// flag bit positions and the PC-relative target helper.
package flag_branch_unit_pkg;

    typedef logic [2:0] zvn_t;
    typedef logic [2:0] ccc_t;

    localparam ccc_t CC_NE     = 3'b000;
    localparam ccc_t CC_EQ     = 3'b001;
    localparam ccc_t CC_GT     = 3'b010;
    localparam ccc_t CC_LT     = 3'b011;
    localparam ccc_t CC_GE     = 3'b100;
    localparam ccc_t CC_LE     = 3'b101;
    localparam ccc_t CC_OVF    = 3'b110;
    localparam ccc_t CC_UNCOND = 3'b111;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Only the arithmetic ops produce meaningful overflow/negative flags.
    function automatic logic writes_vn(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // imm9 is a signed word offset; wrap-around is intentional.
    function automatic logic [15:0] b_target(input logic [15:0] pc_plus2,
                                             input logic [8:0]  imm9);
        return pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};
    endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// Bundle of EX-stage flag inputs, ID-stage branch inputs and unit outputs.
interface flag_branch_unit_if #(parameter int CNT_W = 16);
    import flag_branch_unit_pkg::*;

    // ex_valid / id_valid mark a real instruction in that stage (0 = bubble);
    // there is no ready: stall=1 freezes both stages and suppresses every
    // state update and redirect for that cycle.
    logic             stall;
    logic             ex_valid;
    logic [3:0]       ex_opcode;
    logic             ex_flag_we;
    zvn_t             ex_zvn;
    logic             id_valid;
    logic             id_is_branch;
    logic             id_is_br_reg;
    ccc_t             id_ccc;
    logic [15:0]      id_pc_plus2;
    logic [8:0]       id_imm9;
    logic [15:0]      id_rs_data;

    zvn_t             flags;
    logic             flag_stall;
    logic             branch_taken;
    logic [15:0]      branch_target;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output stall, ex_valid, ex_opcode, ex_flag_we, ex_zvn,
               id_valid, id_is_branch, id_is_br_reg, id_ccc,
               id_pc_plus2, id_imm9, id_rs_data,
        input  flags, flag_stall, branch_taken, branch_target,
               br_count, taken_count
    );

    modport slave (
        input  stall, ex_valid, ex_opcode, ex_flag_we, ex_zvn,
               id_valid, id_is_branch, id_is_br_reg, id_ccc,
               id_pc_plus2, id_imm9, id_rs_data,
        output flags, flag_stall, branch_taken, branch_target,
               br_count, taken_count
    );

endinterface

// File: rtl/flag_branch_unit_branch_cond.sv
// Pure condition evaluator: branch condition code against a {Z,V,N} flag set.
module branch_cond
    import flag_branch_unit_pkg::*;
(
    input  ccc_t ccc,
    input  zvn_t zvn,
    output logic cond
);

    logic z, v, n;

    assign z = zvn[FLAG_Z];
    assign v = zvn[FLAG_V];
    assign n = zvn[FLAG_N];

    always_comb begin
        cond = 1'b1;
        case (ccc)
            CC_NE:   cond = ~z;
            CC_EQ:   cond = z;
            CC_GT:   cond = ~z & ~n;
            CC_LT:   cond = n;
            CC_GE:   cond = z | (~z & ~n);
            CC_LE:   cond = n | z;
            CC_OVF:  cond = v;
            default: cond = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural Z/V/N flag register plus ID-stage branch resolution
// (decision, target, flag-hazard stall) and saturating branch counters.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    flag_branch_unit_if.slave bus
);

    logic             wr;
    logic             vn_wr;
    zvn_t             flags_q;
    zvn_t             flags_next;
    zvn_t             eff;
    logic             hz;
    logic             flag_stall;
    logic             resolve;
    logic             cond;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    assign wr    = bus.ex_valid & bus.ex_flag_we & ~bus.stall;
    assign vn_wr = wr & writes_vn(bus.ex_opcode);

    always_comb begin
        flags_next = flags_q;
        if (wr) begin
            flags_next[FLAG_Z] = bus.ex_zvn[FLAG_Z];
        end
        if (vn_wr) begin
            flags_next[FLAG_V] = bus.ex_zvn[FLAG_V];
            flags_next[FLAG_N] = bus.ex_zvn[FLAG_N];
        end
    end

    // flags_next equals flags_q when nothing is written, so bypass is a plain mux.
    assign eff = BYPASS ? flags_next : flags_q;

    assign hz         = bus.id_valid & bus.id_is_branch & bus.ex_valid & bus.ex_flag_we;
    assign flag_stall = BYPASS ? 1'b0 : hz;
    assign resolve    = bus.id_valid & bus.id_is_branch & ~flag_stall & ~bus.stall;

    branch_cond u_cond (
        .ccc  (bus.id_ccc),
        .zvn  (eff),
        .cond (cond)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q     <= '0;
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            flags_q <= flags_next;
            if (resolve) begin
                if (br_count != '1) begin
                    br_count <= br_count + CNT_W'(1);
                end
                if (cond && (taken_count != '1)) begin
                    taken_count <= taken_count + CNT_W'(1);
                end
            end
        end
    end

    assign bus.flags         = flags_q;
    assign bus.flag_stall    = flag_stall;
    assign bus.branch_taken  = resolve & cond & ~rst;
    assign bus.branch_target = rst              ? 16'h0000 :
                               bus.id_is_br_reg ? bus.id_rs_data :
                               b_target(bus.id_pc_plus2, bus.id_imm9);
    assign bus.br_count      = br_count;
    assign bus.taken_count   = taken_count;

endmodule
